// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: passive observer for the cpu core. Declares halt when the
// fetch PC sits still for HALT_CYCLES cycles, counts RUN cycles and stores,
// and logs every data-memory store into a first-word-fall-through FIFO.
// Optional macro MON_DISPLAY_EN adds simulation-only store/halt messages;
// the default build has no system tasks and is fully synthesizable.
module cpu_run_monitor #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int HALT_CYCLES = 4,
  parameter int CYC_W       = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [ADDR_W-1:0]             pc_i,
  input  logic                          dmem_we_i,
  input  logic [ADDR_W-1:0]             dmem_addr_i,
  input  logic [DATA_W-1:0]             dmem_wdata_i,
  input  logic                          log_pop_i,
  output logic                          log_valid_o,
  output logic [ADDR_W-1:0]             log_addr_o,
  output logic [DATA_W-1:0]             log_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   log_count_o,
  output logic                          log_overflow_o,
  output logic                          done_o,
  output logic [CYC_W-1:0]              cycle_count_o,
  output logic [CYC_W-1:0]              store_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(HALT_CYCLES);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] HALT_LAST  = SW'(HALT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SW-1:0]     stable_q, stable_d;
  logic [CYC_W-1:0]  cycle_q, cycle_d;
  logic [CYC_W-1:0]  store_q, store_d;
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              storeReq;
  logic              fifoFull;
  logic              popEn;
  logic              pushEn;
  logic              dropEn;

  logic [ADDR_W-1:0] memAddr [FIFO_DEPTH];
  logic [DATA_W-1:0] memData [FIFO_DEPTH];

  // A pop on an empty FIFO is ignored; a pop on a full FIFO frees the slot
  // that a simultaneous push then takes, so that push is never dropped.
  assign fifoFull = (count_q == FULL_COUNT);
  assign popEn    = log_pop_i && (count_q != '0);
  assign pushEn   = storeReq && (!fifoFull || popEn);
  assign dropEn   = storeReq && fifoFull && !popEn;

  // Next-state logic for the halt FSM, counters and FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stable_d   = stable_q;
    cycle_d    = cycle_q;
    store_d    = store_q;
    storeReq   = 1'b0;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        pc_d     = pc_i;
        stable_d = '0;
        storeReq = dmem_we_i;
        state_d  = RUN;
      end
      RUN: begin
        pc_d     = pc_i;
        storeReq = dmem_we_i;
        if (cycle_q != '1) cycle_d = cycle_q + CYC_W'(1);
        if (pc_i == pc_q) begin
          if (stable_q == HALT_LAST) state_d = HALTED;
          else                       stable_d = stable_q + SW'(1);
        end else begin
          stable_d = '0;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase

    if (storeReq && (store_q != '1)) store_d = store_q + CYC_W'(1);

    if (pushEn) wrPtr_d = wrPtr_q + AW'(1);
    if (popEn)  rdPtr_d = rdPtr_q + AW'(1);
    if (dropEn) overflow_d = 1'b1;

    unique case ({pushEn, popEn})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards everything including FIFO occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      stable_q   <= '0;
      cycle_q    <= '0;
      store_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      stable_q   <= stable_d;
      cycle_q    <= cycle_d;
      store_q    <= store_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Log storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (!reset_i && pushEn) begin
      memAddr[wrPtr_q] <= dmem_addr_i;
      memData[wrPtr_q] <= dmem_wdata_i;
    end
  end

`ifdef MON_DISPLAY_EN
  // Simulation-only trace of accepted/dropped stores and the halt event.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (pushEn) $display("ST addr=%h data=%h cyc=%0d", dmem_addr_i, dmem_wdata_i, cycle_q);
      if (dropEn) $display("ST DROP addr=%h", dmem_addr_i);
      if (state_q == RUN && state_d == HALTED)
        $display("HALT pc=%h cycles=%0d stores=%0d", pc_i, cycle_d, store_d);
    end
  end
`endif

  assign log_valid_o    = (count_q != '0);
  assign log_addr_o     = log_valid_o ? memAddr[rdPtr_q] : '0;
  assign log_data_o     = log_valid_o ? memData[rdPtr_q] : '0;
  assign log_count_o    = count_q;
  assign log_overflow_o = overflow_q;
  assign done_o         = (state_q == HALTED);
  assign cycle_count_o  = cycle_q;
  assign store_count_o  = store_q;

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Passive observer that sits downstream of the cpu core in simulation and FPGA-debug builds.
- Watches the fetch PC and the data-memory write port.
- Detects program halt (PC stuck in a self-loop), counts cycles and stores, and logs every data-memory store into a FWFT FIFO.
- Benches drain the FIFO and wait on done instead of running a fixed #1000.

Parameters:
- ADDR_W, 32, width of PC and data-memory address.
- DATA_W, 32, width of store data.
- FIFO_DEPTH, 16, store-log entries; power of two, >=2.
- HALT_CYCLES, 4, consecutive cycles with unchanged PC that declare halt; >=2.
- CYC_W, 32, width of cycle and store counters.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc  in  ADDR_W  current fetch PC from cpu.
- dmem_we  in  1  data-memory write enable this cycle.
- dmem_addr  in  ADDR_W  store address.
- dmem_wdata  in  DATA_W  store data.
- log_pop  in  1  consume head entry.
- log_valid  out  1  FIFO non-empty.
- log_addr  out  ADDR_W  head entry address (FWFT).
- log_data  out  DATA_W  head entry data (FWFT).
- log_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- log_overflow  out  1  sticky: a store was dropped because the FIFO was full.
- done  out  1  sticky halt flag.
- cycle_count  out  CYC_W  cycles spent in RUN, saturating.
- store_count  out  CYC_W  stores observed before halt, saturating; includes dropped stores.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE, FIFO empty, log_valid=0, log_count=0.
  - log_addr/log_data=0, log_overflow=0, done=0, cycle_count=0, store_count=0, stable counter=0.
- States:
  - IDLE: capture pc into pc_q; go to RUN next cycle unconditionally.
  - RUN: cycle_count+1 per cycle, saturating at all-ones.
    - If pc==pc_q, stable+1; else stable=0. pc_q<=pc every cycle.
    - When stable==HALT_CYCLES-1 and pc==pc_q, go to HALTED; done=1 from the next cycle.
    - With HALT_CYCLES=4 and PC frozen at cycle t (first equal compare at t+1), done rises at t+5.
  - HALTED: terminal until reset. Counters frozen. Later PC changes are ignored.
- Store capture:
  - In IDLE or RUN with dmem_we=1: store_count+1 (saturating) and push {dmem_addr, dmem_wdata}.
  - In HALTED, dmem_we is ignored entirely.
- FIFO:
  - log_valid = (log_count!=0); the head is presented combinationally from storage (FWFT).
  - log_pop with log_valid=0 is ignored.
  - Push and pop in the same cycle:
    - Non-empty: both occur, log_count unchanged.
    - Full: the pop frees a slot and the push is accepted, so no overflow.
    - Empty: the push is accepted, the pop is ignored, and log_count becomes 1.
  - Push when full without pop: entry dropped, log_overflow=1 (sticky), store_count still increments.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Draining after done is allowed; pops work in every state.
- Reset mid-run: all state is discarded the same cycle, including FIFO contents; monitoring restarts in IDLE.

Optional Feature:
- MON_DISPLAY_EN.
- When defined, simulation-only $display statements print:
  - each accepted store: "ST addr=%h data=%h cyc=%0d";
  - each dropped store: "ST DROP addr=%h";
  - once on entering HALTED: "HALT pc=%h cycles=%0d stores=%0d".
- When undefined, there are no system tasks and the RTL is synthesizable. Cycle-level behaviour is identical either way.

Test Plan:
- Reset, pc incrementing 0,4,8,... with no stores for 20 cycles:
  - done=0, cycle_count=19 (IDLE takes one cycle), log_valid=0.
- Stores (0x40,0x11), (0x44,0x22), (0x48,0x33) on consecutive cycles, then pops:
  - log_count=3.
  - Heads appear in order (0x40,0x11), (0x44,0x22), (0x48,0x33), then log_valid=0.
- 18 stores with FIFO_DEPTH=16 and no pops:
  - log_count=16, log_overflow=1, store_count=18.
  - Drained data are the first 16 stores.
- FIFO full, store and pop in the same cycle:
  - log_count stays 16, log_overflow stays 0.
  - The new entry appears last after draining.
- PC frozen at 0x3C from cycle 10 with HALT_CYCLES=4:
  - done=1 from cycle 15.
  - A subsequent store is not logged and store_count is unchanged.
  - PC moving to 0x40 leaves done=1.
- reset asserted one cycle while the FIFO holds 5 entries in RUN:
  - Next cycle log_count=0, done=0, counters=0, state IDLE.
